// File: rtl/rom_readback.sv
// rom_readback: streams the downloaded ROM/PROM image, address 0 through
// END_ADDR, out of the memory download-side read port onto a valid/ready
// upload stream. It keeps a running 16-bit checksum of the accepted bytes
// so firmware can verify the load.
module rom_readback #(
    parameter logic [15:0] END_ADDR  = 16'hD23F,
    parameter logic [15:0] NIB_START = 16'hD000,
    parameter logic [15:0] NIB_END   = 16'hD1FF,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic        ABORT,
    output logic [15:0] MEM_ADDR,
    output logic        MEM_RD,
    input  logic [7:0]  MEM_DATA,
    output logic [7:0]  OUT_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic        OUT_LAST,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] CHECKSUM
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_PRESENT,
        S_FIN
    } state_t;

    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] lat_cnt;
    logic       handshake;
    logic       capture;
    logic       in_nib;

    // A byte is accepted only when ABORT does not land in the same cycle.
    assign handshake = (state == S_PRESENT) && OUT_READY && !ABORT;

    // The counter is loaded with RD_LAT when WAIT is entered. The byte is
    // captured on the edge that takes it to zero, so WAIT lasts exactly
    // RD_LAT cycles and a byte takes RD_LAT+2 cycles end to end.
    assign capture   = (state == S_WAIT) && (lat_cnt == 2'd1) && !ABORT;

    // The 4-bit LUT PROMs leave their upper data bits undriven.
    assign in_nib    = (MEM_ADDR >= NIB_START) && (MEM_ADDR <= NIB_END);

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        // NOTE: sequential state is only ever updated with non-blocking
        // assignments, so every flop samples pre-edge values regardless of
        // the order in which the simulator evaluates the blocks.
        if (!RESET_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // left one unassigned would infer a latch.
        state_nxt = state;
        MEM_RD    = 1'b0;
        OUT_VALID = 1'b0;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (START) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                MEM_RD    = 1'b1;
                BUSY      = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                BUSY = 1'b1;
                if (lat_cnt == 2'd1) begin
                    state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                OUT_VALID = 1'b1;
                BUSY      = 1'b1;
                if (OUT_READY) begin
                    state_nxt = OUT_LAST ? S_FIN : S_ISSUE;
                end
            end
            S_FIN: begin
                DONE      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // ABORT overrides everything outside IDLE; in IDLE, START wins.
        if (ABORT && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
        end
    end

    // Datapath: address, latency counter, output byte and checksum.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            MEM_ADDR <= 16'h0000;
            lat_cnt  <= 2'd0;
            OUT_DATA <= 8'h00;
            OUT_LAST <= 1'b0;
            CHECKSUM <= 16'h0000;
        end else begin
            if ((state == S_IDLE) && START) begin
                MEM_ADDR <= 16'h0000;
                CHECKSUM <= 16'h0000;
            end

            if (state == S_ISSUE) begin
                lat_cnt <= LAT_LOAD;
            end else if (state == S_WAIT) begin
                lat_cnt <= lat_cnt - 2'd1;
            end

            if (capture) begin
                OUT_DATA <= in_nib ? {4'h0, MEM_DATA[3:0]} : MEM_DATA;
                OUT_LAST <= (MEM_ADDR == END_ADDR);
            end

            // The address stops at END_ADDR; it never wraps past it.
            if (handshake) begin
                CHECKSUM <= CHECKSUM + {8'h00, OUT_DATA};
                if (!OUT_LAST) begin
                    MEM_ADDR <= MEM_ADDR + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_readback.sv
// Bench for rom_readback. Three instances share one clock and one reset:
// A (RD_LAT=1) and B (RD_LAT=3) read a 0x124-byte image that has a nibble
// window at 0x0010..0x001F, and C uses END_ADDR=0. Inputs change 2 time
// units after the rising edge. Monitors sample on the falling edge.
module tb_rom_readback;

    localparam logic [15:0] T_END   = 16'h0123;
    localparam logic [15:0] T_NIB_S = 16'h0010;
    localparam logic [15:0] T_NIB_E = 16'h001F;
    localparam int          N_BYTES = 292;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]  mem [0:511];
    logic [15:0] model_sum = 16'h0000;

    // Instance A signals
    logic        a_start, a_abort, a_ready, a_rd, a_valid, a_last, a_busy, a_done;
    logic [15:0] a_addr, a_sum_dut;
    logic [7:0]  a_mdata, a_data;
    // Instance B signals
    logic        b_start, b_abort, b_ready, b_rd, b_valid, b_last, b_busy, b_done;
    logic [15:0] b_addr, b_sum_dut;
    logic [7:0]  b_mdata, b_data;
    // Instance C signals
    logic        c_start, c_abort, c_ready, c_rd, c_valid, c_last, c_busy, c_done;
    logic [15:0] c_addr, c_sum_dut;
    logic [7:0]  c_mdata, c_data;

    rom_readback #(.END_ADDR(T_END), .NIB_START(T_NIB_S), .NIB_END(T_NIB_E), .RD_LAT(1)) dut_a (
        .CLK(clk), .RESET_N(rst_n), .START(a_start), .ABORT(a_abort),
        .MEM_ADDR(a_addr), .MEM_RD(a_rd), .MEM_DATA(a_mdata),
        .OUT_DATA(a_data), .OUT_VALID(a_valid), .OUT_READY(a_ready), .OUT_LAST(a_last),
        .BUSY(a_busy), .DONE(a_done), .CHECKSUM(a_sum_dut)
    );

    rom_readback #(.END_ADDR(T_END), .NIB_START(T_NIB_S), .NIB_END(T_NIB_E), .RD_LAT(3)) dut_b (
        .CLK(clk), .RESET_N(rst_n), .START(b_start), .ABORT(b_abort),
        .MEM_ADDR(b_addr), .MEM_RD(b_rd), .MEM_DATA(b_mdata),
        .OUT_DATA(b_data), .OUT_VALID(b_valid), .OUT_READY(b_ready), .OUT_LAST(b_last),
        .BUSY(b_busy), .DONE(b_done), .CHECKSUM(b_sum_dut)
    );

    rom_readback #(.END_ADDR(16'h0000), .RD_LAT(1)) dut_c (
        .CLK(clk), .RESET_N(rst_n), .START(c_start), .ABORT(c_abort),
        .MEM_ADDR(c_addr), .MEM_RD(c_rd), .MEM_DATA(c_mdata),
        .OUT_DATA(c_data), .OUT_VALID(c_valid), .OUT_READY(c_ready), .OUT_LAST(c_last),
        .BUSY(c_busy), .DONE(c_done), .CHECKSUM(c_sum_dut)
    );

    // Memory models: data appears RD_LAT edges after the read strobe and holds.
    logic [7:0] pb1, pb2;
    always @(posedge clk) begin
        if (a_rd) a_mdata <= mem[a_addr[8:0]];
        if (b_rd) b_mdata <= mem[b_addr[8:0]];
        pb1 <= b_mdata;
        pb2 <= pb1;
        if (c_rd) c_mdata <= (c_addr == 16'h0000) ? 8'h5A : 8'hEE;
    end

    // Monitor A: records accepted bytes, strobes and handshake spacing.
    int          a_n = 0, a_rd_n = 0, a_done_n = 0, a_cyc = 0, a_last_cyc = 0;
    int          a_gap_min = 1000, a_gap_max = 0;
    logic [15:0] a_hs_addr [0:511];
    logic [7:0]  a_hs_data [0:511];
    logic        a_hs_last [0:511];
    always @(negedge clk) begin
        a_cyc <= a_cyc + 1;
        if (!rst_n) begin
            a_n <= 0; a_rd_n <= 0; a_done_n <= 0;
        end else if (a_start && !a_busy && !a_done) begin
            a_n <= 0; a_rd_n <= 0; a_done_n <= 0; a_gap_min <= 1000; a_gap_max <= 0;
        end else begin
            if (a_rd) a_rd_n <= a_rd_n + 1;
            if (a_done) a_done_n <= a_done_n + 1;
            if (a_valid && a_ready && !a_abort) begin
                a_hs_addr[a_n[8:0]] <= a_addr;
                a_hs_data[a_n[8:0]] <= a_data;
                a_hs_last[a_n[8:0]] <= a_last;
                a_n        <= a_n + 1;
                a_last_cyc <= a_cyc;
                if (a_n != 0) begin
                    if (a_cyc - a_last_cyc < a_gap_min) a_gap_min <= a_cyc - a_last_cyc;
                    if (a_cyc - a_last_cyc > a_gap_max) a_gap_max <= a_cyc - a_last_cyc;
                end
            end
        end
    end

    // Monitor B: records accepted bytes and counts changes while stalled.
    int          b_n = 0, b_rd_n = 0, b_done_n = 0, b_unstable = 0;
    logic        b_stalled = 1'b0, b_pl = 1'b0;
    logic [7:0]  b_pd = 8'h00;
    logic [15:0] b_hs_addr [0:511];
    logic [7:0]  b_hs_data [0:511];
    always @(negedge clk) begin
        if (!rst_n) begin
            b_stalled <= 1'b0;
        end else begin
            if (b_stalled && (b_valid !== 1'b1 || b_data !== b_pd || b_last !== b_pl))
                b_unstable <= b_unstable + 1;
            b_stalled <= b_valid && !b_ready;
            b_pd      <= b_data;
            b_pl      <= b_last;
            if (b_rd) b_rd_n <= b_rd_n + 1;
            if (b_done) b_done_n <= b_done_n + 1;
            if (b_valid && b_ready && !b_abort) begin
                b_hs_addr[b_n[8:0]] <= b_addr;
                b_hs_data[b_n[8:0]] <= b_data;
                b_n <= b_n + 1;
            end
        end
    end

    // Monitor C: counts everything across its single run, never cleared.
    int         c_n = 0, c_rd_n = 0, c_done_n = 0;
    logic [7:0] c_first_data = 8'h00;
    logic       c_first_last = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (c_rd) c_rd_n <= c_rd_n + 1;
            if (c_done) c_done_n <= c_done_n + 1;
            if (c_valid && c_ready && !c_abort) begin
                if (c_n == 0) begin
                    c_first_data <= c_data;
                    c_first_last <= c_last;
                end
                c_n <= c_n + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [7:0] model_byte(input int addr);
        logic [7:0] b;
        b = mem[addr[8:0]];
        if (addr >= 16 && addr <= 31) b = {4'h0, b[3:0]};
        return b;
    endfunction

    initial begin
        {a_start, a_abort, a_ready} = '0;
        {b_start, b_abort, b_ready} = '0;
        {c_start, c_abort, c_ready} = '0;
        for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'(i >> 8);
        mem[9'h00F] = 8'hAB;
        mem[9'h010] = 8'hAB;
        mem[9'h01F] = 8'hFF;
        mem[9'h020] = 8'hFF;
        for (int i = 0; i < N_BYTES; i++) model_sum = model_sum + {8'h00, model_byte(i)};

        // Reset values
        repeat (3) tick();
        check("rst_mem_addr",  32'(a_addr),    32'h0);
        check("rst_mem_rd",    32'(a_rd),      32'h0);
        check("rst_out_data",  32'(a_data),    32'h0);
        check("rst_out_valid", 32'(a_valid),   32'h0);
        check("rst_out_last",  32'(a_last),    32'h0);
        check("rst_busy",      32'(a_busy),    32'h0);
        check("rst_done",      32'(a_done),    32'h0);
        check("rst_checksum",  32'(a_sum_dut), 32'h0);
        rst_n = 1'b1;
        repeat (2) tick();

        // ABORT in IDLE is ignored
        a_abort = 1'b1; tick(); a_abort = 1'b0; tick();
        check("idle_abort_busy", 32'(a_busy), 32'h0);
        check("idle_abort_rd_n", 32'(a_rd_n), 32'h0);

        // Full image: A with OUT_READY high, B with ~30% ready; A gets a START while busy
        a_ready = 1'b1;
        a_start = 1'b1; b_start = 1'b1; tick();
        a_start = 1'b0; b_start = 1'b0; tick();
        a_start = 1'b1; tick(); a_start = 1'b0;
        for (int cyc = 0; cyc < 20000 && !(a_done_n >= 1 && b_done_n >= 1); cyc++) begin
            b_ready = ($urandom_range(0, 9) < 3);
            tick();
        end
        b_ready = 1'b0;
        check("full_finished", 32'(a_done_n >= 1 && b_done_n >= 1), 32'h1);
        repeat (4) tick();
        check("a_bytes",    32'(a_n),       32'(N_BYTES));
        for (int i = 0; i < N_BYTES; i++) begin
            check("a_addr", 32'(a_hs_addr[9'(i)]), 32'(i));
            check("a_data", 32'(a_hs_data[9'(i)]), 32'(model_byte(i)));
            check("a_last", 32'(a_hs_last[9'(i)]), 32'(i == N_BYTES - 1));
        end
        check("a_checksum", 32'(a_sum_dut), 32'(model_sum));
        check("a_done_n",   32'(a_done_n),  32'h1);
        check("a_rd_n",     32'(a_rd_n),    32'(N_BYTES));
        check("a_gap_min",  32'(a_gap_min), 32'h3);
        check("a_gap_max",  32'(a_gap_max), 32'h3);
        check("a_busy_end", 32'(a_busy),    32'h0);
        check("a_addr_end", 32'(a_addr),    32'(T_END));
        // Nibble window boundaries
        check("nib_0x0F", 32'(a_hs_data[9'h00F]), 32'hAB);
        check("nib_0x10", 32'(a_hs_data[9'h010]), 32'h0B);
        check("nib_0x1F", 32'(a_hs_data[9'h01F]), 32'h0F);
        check("nib_0x20", 32'(a_hs_data[9'h020]), 32'hFF);
        // Backpressure stream on B
        check("b_bytes", 32'(b_n), 32'(N_BYTES));
        for (int i = 0; i < N_BYTES; i++) begin
            check("b_addr", 32'(b_hs_addr[9'(i)]), 32'(i));
            check("b_data", 32'(b_hs_data[9'(i)]), 32'(model_byte(i)));
        end
        check("b_checksum", 32'(b_sum_dut),  32'(model_sum));
        check("b_unstable", 32'(b_unstable), 32'h0);
        check("b_rd_n",     32'(b_rd_n),     32'(N_BYTES));
        check("b_done_n",   32'(b_done_n),   32'h1);

        // Abort in the handshake cycle of byte 0x0010
        a_start = 1'b1; tick(); a_start = 1'b0;
        for (int cyc = 0; cyc < 200 && !(a_valid && a_addr == 16'h0010); cyc++) tick();
        check("abort_reach", 32'(a_valid && a_addr == 16'h0010), 32'h1);
        a_abort = 1'b1; tick(); a_abort = 1'b0;
        check("abort_busy",     32'(a_busy),    32'h0);
        check("abort_valid",    32'(a_valid),   32'h0);
        check("abort_checksum", 32'(a_sum_dut), 32'h0114);
        check("abort_addr",     32'(a_addr),    32'h0010);
        check("abort_bytes",    32'(a_n),       32'd16);
        repeat (3) tick();
        check("abort_done_n",   32'(a_done_n),  32'h0);
        check("abort_rd_n",     32'(a_rd_n),    32'd17);
        // Restart after abort
        a_start = 1'b1; tick(); a_start = 1'b0;
        check("restart_addr",     32'(a_addr),    32'h0);
        check("restart_checksum", 32'(a_sum_dut), 32'h0);
        check("restart_busy",     32'(a_busy),    32'h1);
        for (int cyc = 0; cyc < 50 && a_n < 1; cyc++) tick();
        check("restart_first_addr", 32'(a_hs_addr[0]), 32'h0);
        check("restart_first_data", 32'(a_hs_data[0]), 32'(model_byte(0)));
        a_abort = 1'b1; tick(); a_abort = 1'b0;

        // Asynchronous reset while in WAIT
        a_start = 1'b1; tick(); a_start = 1'b0; tick();
        check("rmo_in_wait", 32'(a_busy && !a_valid && !a_rd), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("rmo_mem_addr", 32'(a_addr),    32'h0);
        check("rmo_busy",     32'(a_busy),    32'h0);
        check("rmo_valid",    32'(a_valid),   32'h0);
        check("rmo_rd",       32'(a_rd),      32'h0);
        check("rmo_done",     32'(a_done),    32'h0);
        check("rmo_checksum", 32'(a_sum_dut), 32'h0);
        check("rmo_out_data", 32'(a_data),    32'h0);
        check("rmo_out_last", 32'(a_last),    32'h0);
        repeat (2) tick();
        rst_n = 1'b1; tick();
        a_start = 1'b1; tick(); a_start = 1'b0;
        for (int cyc = 0; cyc < 2000 && a_done_n < 1; cyc++) tick();
        repeat (2) tick();
        check("rmo_rerun_bytes",    32'(a_n),       32'(N_BYTES));
        check("rmo_rerun_checksum", 32'(a_sum_dut), 32'(model_sum));
        check("rmo_rerun_done_n",   32'(a_done_n),  32'h1);

        // END_ADDR=0 single byte; second START while busy ignored
        c_ready = 1'b1;
        c_start = 1'b1; tick(); c_start = 1'b0; tick();
        c_start = 1'b1; tick(); c_start = 1'b0;
        for (int cyc = 0; cyc < 50 && c_done_n < 1; cyc++) tick();
        repeat (10) tick();
        check("c_bytes",    32'(c_n),          32'h1);
        check("c_data",     32'(c_first_data), 32'h5A);
        check("c_last",     32'(c_first_last), 32'h1);
        check("c_checksum", 32'(c_sum_dut),    32'h005A);
        check("c_done_n",   32'(c_done_n),     32'h1);
        check("c_rd_n",     32'(c_rd_n),       32'h1);
        check("c_busy",     32'(c_busy),       32'h0);
        check("c_addr",     32'(c_addr),       32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
